// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: occupancy encoding and default widths used by
// every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_stage_skid_pkg;

  localparam int PIPE_DATA_W = 40;
  localparam int PIPE_CTRL_W = 8;
  localparam int PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_st_e;

  function automatic logic st_can_accept(input stage_st_e s);
    return (s != ST_FULL);
  endfunction

  function automatic logic st_has_beat(input stage_st_e s);
    return (s != ST_EMPTY);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Plain register with asynchronous active-low clear; load/zero muxing is done
// by the instantiating stage.
module pipe_stage_skid_reg #(
  parameter int size = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [size-1:0] regIn,
  output logic [size-1:0] regOut
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) regOut <= '0;
    else        regOut <= regIn;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage: main register feeds the next stage, the skid
// register catches the beat accepted while downstream stalls.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [DATA_W-1:0] CTRL_MASK = {DATA_W{1'b1}} >> (DATA_W - CTRL_W);

  stage_st_e         r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [CNT_W-1:0]  r_stall;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_in_fire;
  logic              w_out_fire;

  // Handshake outputs decode from state only, so out_ready never reaches in_ready.
  assign in_ready   = st_can_accept(r_state);
  assign out_valid  = st_has_beat(r_state);
  assign out_data   = r_main;
  assign stall_cnt  = r_stall;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Going empty clears only the control LSBs so a consumer ignoring out_valid
  // performs no write; operand bits keep their previous value.
  always_comb begin
    w_main_nxt = r_main;
    w_skid_nxt = r_skid;
    if (flush) begin
      w_main_nxt = r_main & ~CTRL_MASK;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) w_main_nxt = in_data;
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) w_main_nxt = in_data;
          else if (w_in_fire)          w_skid_nxt = in_data;
          else if (w_out_fire)         w_main_nxt = r_main & ~CTRL_MASK;
        end
        ST_FULL: begin
          if (w_out_fire) w_main_nxt = r_skid;
        end
        default: w_main_nxt = r_main & ~CTRL_MASK;
      endcase
    end
  end

  pipe_stage_skid_reg #(.size(DATA_W)) u_main (
    .clock  (clk),
    .reset  (rst),
    .regIn  (w_main_nxt),
    .regOut (r_main)
  );

  pipe_stage_skid_reg #(.size(DATA_W)) u_skid (
    .clock  (clk),
    .reset  (rst),
    .regIn  (w_skid_nxt),
    .regOut (r_skid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      r_state <= ST_FULL;
          else if (!w_in_fire && w_out_fire) r_state <= ST_EMPTY;
        end
        ST_FULL:  if (w_out_fire) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        r_stall <= '0;
    else if (out_valid && !out_ready && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed handshake/flush/reset/saturation
// cases followed by randomized traffic against a queue-based FIFO model.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int DATA_W = PIPE_DATA_W;
  localparam int CTRL_W = PIPE_CTRL_W;
  localparam int CNT_W  = PIPE_CNT_W;
  localparam logic [DATA_W-1:0] CTRL_MASK = DATA_W'((64'd1 << CTRL_W) - 64'd1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              flush = 1'b0;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_skid dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and are consumed at the next one.
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // Reference model: the stage is a 2-deep FIFO; flush empties it.
  logic [DATA_W-1:0] exp_q[$];
  logic [CNT_W-1:0]  exp_stall;
  logic [DATA_W-1:0] prev_out;
  int                emitted;

  initial begin : monitor
    exp_stall = '0;
    prev_out  = '0;
    emitted   = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        exp_stall = '0;
        prev_out  = '0;
      end else begin
        chk("in_ready",  64'(in_ready),  64'(exp_q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        if (exp_q.size() != 0) begin
          chk("out_data", 64'(out_data), 64'(exp_q[0]));
        end else begin
          chk("bubble_ctrl",  64'(out_data & CTRL_MASK), 64'd0);
          chk("bubble_upper", 64'(out_data & ~CTRL_MASK), 64'(prev_out & ~CTRL_MASK));
        end
        if (exp_q.size() != 0 && !out_ready && exp_stall != {CNT_W{1'b1}})
          exp_stall = exp_stall + 1'b1;
        if (flush) begin
          exp_q.delete();
        end else begin
          logic can_take;
          can_take = (exp_q.size() < 2);
          if (exp_q.size() != 0 && out_ready) begin
            void'(exp_q.pop_front());
            emitted++;
          end
          if (in_valid && can_take) exp_q.push_back(in_data);
        end
        prev_out = out_data;
      end
    end
  end

  logic [DATA_W-1:0] rd;
  int                mark;

  initial begin : stim
    #2 rst = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    #18 rst = 1'b1;

    // Single beat, empty stage, downstream ready.
    drive(1'b1, 40'h12_3456_78AB, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_data",  64'(out_data),  64'h12_3456_78AB);
    chk("lat_in_ready",  64'(in_ready),  64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Fill to FULL, then release: A..D in order.
    mark = emitted;
    drive(1'b1, 40'hA0_0000_00A1, 1'b1, 1'b0);
    drive(1'b1, 40'hB0_0000_00B2, 1'b0, 1'b0);
    drive(1'b1, 40'hC0_0000_00C3, 1'b0, 1'b0);
    #1;
    chk("full_in_ready",  64'(in_ready),  64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_out_data",  64'(out_data),  64'hA0_0000_00A1);
    drive(1'b1, 40'hC0_0000_00C3, 1'b1, 1'b0);
    drive(1'b1, 40'hC0_0000_00C3, 1'b1, 1'b0);
    drive(1'b1, 40'hD0_0000_00D4, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("abcd_emitted", 64'(emitted - mark), 64'd4);

    // Flush while FULL with a beat offered.
    drive(1'b1, 40'hE5_5555_55E5, 1'b0, 1'b0);
    drive(1'b1, 40'hF6_6666_66F6, 1'b0, 1'b0);
    drive(1'b1, 40'h77_7777_7777, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl",      64'(out_data[7:0]), 64'd0);
    chk("flush_upper",     64'(out_data[DATA_W-1:8]), 64'hE5_5555_55);
    chk("flush_in_ready",  64'(in_ready), 64'd1);
    mark = emitted;
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("flush_no_emit", 64'(emitted - mark), 64'd0);

    // Long stall saturates the counter.
    drive(1'b1, 40'h99_1234_5699, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (65600) @(posedge clk);
    #1;
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL.
    drive(1'b1, 40'h11_1111_1111, 1'b0, 1'b0);
    drive(1'b1, 40'h22_2222_2222, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data",  64'(out_data),  64'd0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    drive(1'b1, 40'h3C_3C3C_3C3C, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data",  64'(out_data),  64'h3C_3C3C_3C3C);

    // Random traffic with alternating high/low back-pressure phases.
    mark = emitted;
    for (int i = 0; i < 12000; i++) begin
      rd = DATA_W'({$urandom, $urandom});
      drive($urandom_range(0, 3) != 0, rd,
            (((i / 64) % 2) != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 40) == 0);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("rand_traffic_flowed", 64'(emitted - mark > 1000), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
